// File: rtl/apb_rr_scheduler.sv
// apb_rr_scheduler: round-robin arbiter that shares one APB requester port
// among NUM_REQ local requesters. Each granted command is sequenced through
// SETUP/ACCESS and its response is returned to the owner with a one-cycle
// o_DONE pulse.
// Optional build macro APB_TIMEOUT_EN: aborts an ACCESS phase after 1024
// consecutive cycles without i_PREADY and reports an error to the owner.
module apb_rr_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int SEL_WIDTH  = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          i_CLK,
   input  logic                          i_RESETn,
   input  logic [NUM_REQ-1:0]            i_REQ,
   input  logic [NUM_REQ-1:0]            i_WRITE,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_ADDR,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_WDATA,
   output logic [NUM_REQ-1:0]            o_GNT,
   output logic [NUM_REQ-1:0]            o_DONE,
   output logic [DATA_WIDTH-1:0]         o_RDATA,
   output logic                          o_ERR,
   output logic [SEL_WIDTH-1:0]          o_PSEL,
   output logic                          o_PENABLE,
   output logic                          o_PWRITE,
   output logic [ADDR_WIDTH-1:0]         o_PADDR,
   output logic [DATA_WIDTH-1:0]         o_PWDATA,
   input  logic                          i_PREADY,
   input  logic [DATA_WIDTH-1:0]         i_PRDATA,
   input  logic                          i_PSLVERR
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int DEC_W = $clog2(SEL_WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [PTR_W-1:0]       owner_q, owner_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic [NUM_REQ-1:0]     done_q, done_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [SEL_WIDTH-1:0]   psel_q, psel_d;
   logic                   penable_q, penable_d;
   logic                   pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
`ifdef APB_TIMEOUT_EN
   logic [15:0]            tmo_q, tmo_d;
`endif

   logic                   req_any;
   logic [PTR_W-1:0]       pick_idx;
   int                     pick_int;
   logic [ADDR_WIDTH-1:0]  pick_addr;
   logic [DATA_WIDTH-1:0]  pick_wdata;
   logic                   pick_write;
   logic [DEC_W-1:0]       dec_idx;
   logic                   pick_mapped;
   logic [SEL_WIDTH-1:0]   pick_sel;

   // Round-robin pick: scan downwards so the candidate closest to the pointer wins
   always_comb begin
      int cand;
      cand     = 0;
      req_any  = 1'b0;
      pick_int = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = int'(ptr_q) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (i_REQ[cand]) begin
            req_any  = 1'b1;
            pick_int = cand;
         end
      end
      pick_idx = PTR_W'(pick_int);
   end

   // Fetch the picked command and decode its slave select from the top address bits
   always_comb begin
      pick_addr   = i_ADDR[pick_int*ADDR_WIDTH +: ADDR_WIDTH];
      pick_wdata  = i_WDATA[pick_int*DATA_WIDTH +: DATA_WIDTH];
      pick_write  = i_WRITE[pick_int];
      dec_idx     = pick_addr[ADDR_WIDTH-1 -: DEC_W];
      pick_mapped = (int'(dec_idx) < SEL_WIDTH);
      pick_sel    = '0;
      for (int s = 0; s < SEL_WIDTH; s++) begin
         pick_sel[s] = (int'(dec_idx) == s);
      end
   end

   // Next-state and registered-output logic for the transfer sequencer
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
`ifdef APB_TIMEOUT_EN
      tmo_d     = tmo_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               owner_d           = pick_idx;
               gnt_d             = '0;
               gnt_d[pick_idx]   = 1'b1;
               paddr_d           = pick_addr;
               pwrite_d          = pick_write;
               pwdata_d          = pick_wdata;
               if (pick_mapped) begin
                  psel_d  = pick_sel;
                  state_d = ST_SETUP;
               end else begin
                  psel_d           = '0;
                  rdata_d          = '0;
                  err_d            = 1'b1;
                  done_d[pick_idx] = 1'b1;
                  state_d          = ST_RESP;
               end
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
            tmo_d     = '0;
`endif
         end
         ST_ACCESS: begin
            if (i_PREADY) begin
               psel_d    = '0;
               penable_d = 1'b0;
               rdata_d   = pwrite_q ? '0 : i_PRDATA;
               err_d     = i_PSLVERR;
               done_d    = gnt_q;
               state_d   = ST_RESP;
            end
`ifdef APB_TIMEOUT_EN
            else if (tmo_q == 16'd1023) begin
               psel_d    = '0;
               penable_d = 1'b0;
               rdata_d   = '0;
               err_d     = 1'b1;
               done_d    = gnt_q;
               state_d   = ST_RESP;
            end else begin
               tmo_d     = tmo_q + 16'd1;
            end
`endif
         end
         ST_RESP: begin
            gnt_d   = '0;
            ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything, including an in-flight transfer
   always_ff @(posedge i_CLK or negedge i_RESETn) begin
      if (!i_RESETn) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
`ifdef APB_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
`ifdef APB_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign o_GNT     = gnt_q;
   assign o_DONE    = done_q;
   assign o_RDATA   = rdata_q;
   assign o_ERR     = err_q;
   assign o_PSEL    = psel_q;
   assign o_PENABLE = penable_q;
   assign o_PWRITE  = pwrite_q;
   assign o_PADDR   = paddr_q;
   assign o_PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// tb_apb_rr_scheduler: directed and randomized transfers against a
// transaction-level model (round-robin pick, address decode, response rules).
// Build with APB_TIMEOUT_EN defined to also exercise the ACCESS timeout.
module tb_apb_rr_scheduler;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 3;
   localparam int AW      = 32;
   localparam int DW      = 32;

   logic                   i_CLK;
   logic                   i_RESETn;
   logic [NUM_REQ-1:0]     i_REQ;
   logic [NUM_REQ-1:0]     i_WRITE;
   logic [NUM_REQ*AW-1:0]  i_ADDR;
   logic [NUM_REQ*DW-1:0]  i_WDATA;
   logic [NUM_REQ-1:0]     o_GNT;
   logic [NUM_REQ-1:0]     o_DONE;
   logic [DW-1:0]          o_RDATA;
   logic                   o_ERR;
   logic [SEL_W-1:0]       o_PSEL;
   logic                   o_PENABLE;
   logic                   o_PWRITE;
   logic [AW-1:0]          o_PADDR;
   logic [DW-1:0]          o_PWDATA;
   logic                   i_PREADY;
   logic [DW-1:0]          i_PRDATA;
   logic                   i_PSLVERR;

   int checks   = 0;
   int failures = 0;
   int model_ptr;
   logic [AW-1:0] cmd_addr  [NUM_REQ];
   logic [DW-1:0] cmd_wdata [NUM_REQ];
   logic          cmd_write [NUM_REQ];

   apb_rr_scheduler #(
      .NUM_REQ    (NUM_REQ),
      .SEL_WIDTH  (SEL_W),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .i_CLK     (i_CLK),
      .i_RESETn  (i_RESETn),
      .i_REQ     (i_REQ),
      .i_WRITE   (i_WRITE),
      .i_ADDR    (i_ADDR),
      .i_WDATA   (i_WDATA),
      .o_GNT     (o_GNT),
      .o_DONE    (o_DONE),
      .o_RDATA   (o_RDATA),
      .o_ERR     (o_ERR),
      .o_PSEL    (o_PSEL),
      .o_PENABLE (o_PENABLE),
      .o_PWRITE  (o_PWRITE),
      .o_PADDR   (o_PADDR),
      .o_PWDATA  (o_PWDATA),
      .i_PREADY  (i_PREADY),
      .i_PRDATA  (i_PRDATA),
      .i_PSLVERR (i_PSLVERR)
   );

   // Free-running 100 MHz clock
   initial i_CLK = 1'b0;
   always #5 i_CLK = ~i_CLK;

   // Hard stop in case something hangs outside the bounded waits
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Present a command on requester k and raise its request
   task automatic applyStimulus(input int k, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      cmd_addr[k]            = addr;
      cmd_wdata[k]           = data;
      cmd_write[k]           = wr;
      i_WRITE[k]             = wr;
      i_ADDR[k*AW +: AW]     = addr;
      i_WDATA[k*DW +: DW]    = data;
      i_REQ[k]               = 1'b1;
   endtask

   // Model: first pending requester at or after the pointer, modulo NUM_REQ
   function automatic int expectedOwner();
      int c;
      for (int i = 0; i < NUM_REQ; i++) begin
         c = (model_ptr + i) % NUM_REQ;
         if (i_REQ[c]) return c;
      end
      return -1;
   endfunction

   // One whole transfer: grant, SETUP, ws wait states, response; returns owner and observed grant
   task automatic runTransfer(input int ws, input logic slv_err, input logic [DW-1:0] rd_val,
                              output int owner, output logic [NUM_REQ-1:0] gnt_seen, output int gnt_wait);
      logic [AW-1:0] a;
      int            slv;
      bit            timed_out;
      owner     = expectedOwner();
      gnt_wait  = 0;
      timed_out = 1'b1;
      gnt_seen  = '0;
      for (int t = 0; t < 8; t++) begin
         @(negedge i_CLK);
         gnt_wait++;
         if (o_GNT != '0) begin
            timed_out = 1'b0;
            break;
         end
      end
      checkOutput("gnt_timeout", timed_out, 0);
      if (timed_out || owner < 0) return;
      gnt_seen = o_GNT;
      checkOutput("gnt_owner", o_GNT, 1 << owner);
      // Later changes to the owner's command must not leak onto the bus
      i_ADDR[owner*AW +: AW]  = $urandom;
      i_WDATA[owner*DW +: DW] = $urandom;
      i_WRITE[owner]          = ~cmd_write[owner];
      a   = cmd_addr[owner];
      slv = int'(a[AW-1 -: 2]);
      if (slv < SEL_W) begin
         checkOutput("setup_psel",    o_PSEL, 1 << slv);
         checkOutput("setup_penable", o_PENABLE, 0);
         checkOutput("setup_paddr",   o_PADDR, a);
         checkOutput("setup_pwrite",  o_PWRITE, cmd_write[owner]);
         checkOutput("setup_pwdata",  o_PWDATA, cmd_wdata[owner]);
         checkOutput("setup_done",    o_DONE, 0);
         i_PREADY = 1'b0;
         for (int k = 0; k <= ws; k++) begin
            @(negedge i_CLK);
            checkOutput("access_penable", o_PENABLE, 1);
            checkOutput("access_psel",    o_PSEL, 1 << slv);
            checkOutput("access_paddr",   o_PADDR, a);
            checkOutput("access_pwdata",  o_PWDATA, cmd_wdata[owner]);
            checkOutput("access_done",    o_DONE, 0);
            i_PREADY  = (k == ws);
            i_PRDATA  = (k == ws) ? rd_val : $urandom;
            i_PSLVERR = (k == ws) ? slv_err : 1'($urandom);
         end
         @(negedge i_CLK);
         i_PREADY  = 1'b0;
         i_PSLVERR = 1'b0;
         checkOutput("resp_done",    o_DONE, 1 << owner);
         checkOutput("resp_rdata",   o_RDATA, cmd_write[owner] ? '0 : rd_val);
         checkOutput("resp_err",     o_ERR, slv_err);
         checkOutput("resp_psel",    o_PSEL, 0);
         checkOutput("resp_penable", o_PENABLE, 0);
      end else begin
         checkOutput("unmapped_psel",    o_PSEL, 0);
         checkOutput("unmapped_penable", o_PENABLE, 0);
         checkOutput("unmapped_done",    o_DONE, 1 << owner);
         checkOutput("unmapped_err",     o_ERR, 1);
         checkOutput("unmapped_rdata",   o_RDATA, 0);
      end
      i_REQ[owner] = 1'b0;
      model_ptr    = (owner + 1) % NUM_REQ;
      @(negedge i_CLK);
      checkOutput("idle_done_pulse", o_DONE, 0);
      checkOutput("idle_gnt",        o_GNT, 0);
   endtask

   int                 owner;
   int                 gnt_wait;
   logic [NUM_REQ-1:0] gnt_seen;
   int                 rr_order [5] = '{0, 1, 2, 3, 0};
   bit                 waited;

   // Directed steps followed by a randomized phase
   initial begin
      i_RESETn = 1'b0;
      i_REQ    = '0;
      i_WRITE  = '0;
      i_ADDR   = '0;
      i_WDATA  = '0;
      i_PREADY = 1'b0;
      i_PRDATA = '0;
      i_PSLVERR = 1'b0;
      model_ptr = 0;
      repeat (2) @(negedge i_CLK);
      checkOutput("rst_gnt",     o_GNT, 0);
      checkOutput("rst_done",    o_DONE, 0);
      checkOutput("rst_psel",    o_PSEL, 0);
      checkOutput("rst_penable", o_PENABLE, 0);
      checkOutput("rst_paddr",   o_PADDR, 0);
      checkOutput("rst_rdata",   o_RDATA, 0);
      checkOutput("rst_err",     o_ERR, 0);
      i_RESETn = 1'b1;
      @(negedge i_CLK);

      $display("[TB] single read");
      applyStimulus(1, 1'b0, 32'h4000_0010, 32'h0);
      runTransfer(0, 1'b0, 32'hDEAD_BEEF, owner, gnt_seen, gnt_wait);
      checkOutput("read_gnt_latency", gnt_wait, 1);
      checkOutput("read_gnt_vec",     gnt_seen, 4'b0010);

      $display("[TB] write with wait states");
      applyStimulus(0, 1'b1, 32'h0000_0004, 32'h1234_5678);
      runTransfer(3, 1'b0, 32'hFFFF_FFFF, owner, gnt_seen, gnt_wait);

      $display("[TB] unmapped address");
      applyStimulus(2, 1'b0, 32'hC000_0000, 32'h0);
      runTransfer(0, 1'b0, 32'h0, owner, gnt_seen, gnt_wait);

      $display("[TB] slave error then normal");
      applyStimulus(3, 1'b1, 32'h8000_0008, 32'hA5A5_0001);
      runTransfer(1, 1'b1, 32'h0, owner, gnt_seen, gnt_wait);
      applyStimulus(0, 1'b0, 32'h4000_0000, 32'h0);
      runTransfer(0, 1'b0, 32'h0BAD_F00D, owner, gnt_seen, gnt_wait);

      $display("[TB] reset during access");
      applyStimulus(2, 1'b0, 32'h4000_0020, 32'h0);
      i_PREADY = 1'b0;
      waited = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(negedge i_CLK);
         if (o_GNT != '0) begin
            waited = 1'b0;
            break;
         end
      end
      checkOutput("rst_mid_gnt_timeout", waited, 0);
      repeat (2) @(negedge i_CLK);
      checkOutput("rst_mid_in_access", o_PENABLE, 1);
      #2 i_RESETn = 1'b0;
      #1;
      checkOutput("rst_mid_psel",    o_PSEL, 0);
      checkOutput("rst_mid_penable", o_PENABLE, 0);
      checkOutput("rst_mid_gnt",     o_GNT, 0);
      checkOutput("rst_mid_paddr",   o_PADDR, 0);
      checkOutput("rst_mid_pwrite",  o_PWRITE, 0);
      i_REQ = '0;
      repeat (2) @(negedge i_CLK);
      checkOutput("rst_mid_no_done", o_DONE, 0);
      for (int k = 0; k < NUM_REQ; k++) begin
         applyStimulus(k, 1'b0, {2'(k % 3), 30'(k * 16)}, 32'h0);
      end
      model_ptr = 0;
      i_RESETn  = 1'b1;

      $display("[TB] round robin");
      for (int i = 0; i < 5; i++) begin
         runTransfer(int'($urandom_range(0, 2)), 1'b0, $urandom, owner, gnt_seen, gnt_wait);
         checkOutput("rr_order", gnt_seen, 1 << rr_order[i]);
         if (owner >= 0) applyStimulus(owner, 1'($urandom), {2'(owner % 3), 30'($urandom)}, $urandom);
      end
      i_REQ = '0;
      repeat (3) begin
         @(negedge i_CLK);
         checkOutput("dropped_req_no_gnt", o_GNT, 0);
      end

      $display("[TB] randomized transfers");
      for (int n = 0; n < 24; n++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!i_REQ[k] && $urandom_range(0, 1) == 1) begin
               applyStimulus(k, 1'($urandom), {2'($urandom_range(0, 3)), 30'($urandom)}, $urandom);
            end
         end
         if (i_REQ == '0) begin
            applyStimulus(n % NUM_REQ, 1'($urandom), {2'($urandom_range(0, 3)), 30'($urandom)}, $urandom);
         end
         runTransfer(int'($urandom_range(0, 3)), 1'($urandom), $urandom, owner, gnt_seen, gnt_wait);
      end
      while (i_REQ != '0) begin
         runTransfer(0, 1'b0, $urandom, owner, gnt_seen, gnt_wait);
         if (owner < 0) i_REQ = '0;
      end

`ifdef APB_TIMEOUT_EN
      $display("[TB] access timeout");
      applyStimulus(1, 1'b0, 32'h0000_0100, 32'h0);
      i_PREADY = 1'b0;
      waited = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(negedge i_CLK);
         if (o_GNT != '0) begin
            waited = 1'b0;
            break;
         end
      end
      checkOutput("tmo_gnt_timeout", waited, 0);
      gnt_wait = 0;
      for (int t = 0; t < 1100; t++) begin
         @(negedge i_CLK);
         if (!o_PENABLE) break;
         gnt_wait++;
      end
      checkOutput("tmo_access_cycles", gnt_wait, 1024);
      checkOutput("tmo_done",  o_DONE, 4'b0010);
      checkOutput("tmo_err",   o_ERR, 1);
      checkOutput("tmo_rdata", o_RDATA, 0);
      checkOutput("tmo_psel",  o_PSEL, 0);
      i_REQ[1] = 1'b0;
      @(negedge i_CLK);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
